// File: rtl/ikascc_voice_timer_sched_pkg.sv
// Shared defaults and helpers for the SCC voice timer scheduler.
// Slot indices are 3 bits, so up to 8 voices can share the count unit.
package ikascc_voice_timer_sched_pkg;

  localparam int NCH_DEF    = 5;
  localparam int PW_DEF     = 12;
  localparam int AW_DEF     = 5;
  localparam int PMIN_DEF   = 9;
  localparam int SLOT_W     = 3;
  localparam int WADDR_WRAP = (1 << AW_DEF) - 1;

  // Round-robin successor of a slot for a given voice count.
  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s, input int nch);
    if (32'(s) >= nch - 1) slot_next = '0;
    else                   slot_next = s + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/ikascc_voice_timer_sched_cnt_unit.sv
// Shared period down-count unit: reloads from the period on borrow, otherwise decrements.
// Combinational; the owning slot's registers are muxed in by the top level.
module ikascc_voice_cnt_unit #(
  parameter int PW = 12
) (
  input  logic [PW-1:0] i_cnt,
  input  logic [PW-1:0] i_period,
  input  logic          i_run,
  output logic [PW-1:0] o_cnt_nxt,
  output logic          o_borrow
);

  always_comb begin
    o_cnt_nxt = i_cnt;
    o_borrow  = 1'b0;
    if (i_run) begin
      if (i_cnt == '0) begin
        o_cnt_nxt = i_period;
        o_borrow  = 1'b1;
      end else begin
        o_cnt_nxt = i_cnt - PW'(1);
      end
    end
  end

endmodule

// File: rtl/ikascc_voice_timer_sched.sv
// SCC voice timer scheduler: one count unit time-shared round-robin across NCH voices,
// stepping each voice's wave address once per (period+1)*NCH enabled cycles.
module ikascc_voice_timer_sched
  import ikascc_voice_timer_sched_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int PW   = PW_DEF,
  parameter int AW   = AW_DEF,
  parameter int PMIN = PMIN_DEF
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST_n,
  input  logic              i_MCLK_PCEN_n,
  input  logic              i_FREQ_WR,
  input  logic [2:0]        i_FREQ_CH,
  input  logic [PW-1:0]     i_FREQ_D,
  input  logic              i_RESTART,
  input  logic [NCH-1:0]    i_CH_EN,
  output logic [2:0]        o_SLOT,
  output logic              o_STEP,
  output logic [2:0]        o_STEP_CH,
  output logic [NCH*AW-1:0] o_WADDR
);

  localparam logic [PW-1:0] PMIN_V = PW'(PMIN);

  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [NCH-1:0][PW-1:0]     period_q, period_d;
  logic [NCH-1:0][PW-1:0]     cnt_q, cnt_d;
  logic [NCH-1:0][AW-1:0]     waddr_q, waddr_d;
  logic                       step_q, step_d;
  logic [SLOT_W-1:0]          step_ch_q, step_ch_d;

  logic          en;
  logic          run;
  logic          wr_ok;
  logic [PW-1:0] cu_cnt_nxt;
  logic          cu_borrow;

  assign en    = ~i_MCLK_PCEN_n;
  assign run   = i_CH_EN[slot_q] && (period_q[slot_q] >= PMIN_V);
  assign wr_ok = i_FREQ_WR && (32'(i_FREQ_CH) < NCH);

  ikascc_voice_cnt_unit #(.PW(PW)) u_cnt (
    .i_cnt     (cnt_q[slot_q]),
    .i_period  (period_q[slot_q]),
    .i_run     (run),
    .o_cnt_nxt (cu_cnt_nxt),
    .o_borrow  (cu_borrow)
  );

  always_comb begin
    slot_d    = slot_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    step_d    = step_q;
    step_ch_d = step_ch_q;
    if (en) begin
      slot_d        = slot_next(slot_q, NCH);
      cnt_d[slot_q] = cu_cnt_nxt;
      step_d        = cu_borrow;
      if (cu_borrow) begin
        waddr_d[slot_q] = waddr_q[slot_q] + AW'(1);
        step_ch_d       = slot_q;
      end
      // Writes are merged after the visit so a restart overrides that voice's visit result.
      if (wr_ok) begin
        period_d[i_FREQ_CH] = i_FREQ_D;
        if (i_RESTART) begin
          cnt_d[i_FREQ_CH]   = i_FREQ_D;
          waddr_d[i_FREQ_CH] = '0;
          if (i_FREQ_CH == slot_q) begin
            step_d    = 1'b0;
            step_ch_d = step_ch_q;
          end
        end
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      slot_q    <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      waddr_q   <= '0;
      step_q    <= 1'b0;
      step_ch_q <= '0;
    end else begin
      slot_q    <= slot_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      waddr_q   <= waddr_d;
      step_q    <= step_d;
      step_ch_q <= step_ch_d;
    end
  end

  assign o_SLOT    = slot_q;
  assign o_STEP    = step_q;
  assign o_STEP_CH = step_ch_q;
  assign o_WADDR   = waddr_q;

endmodule
